down_counter_timer: RTL and testbench
=====================================

DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the counter width in bits.
REQ-002 Parameter PRESCALE, default 4, SHALL set the number of Clk cycles per decrement; legal range is 1 to 2^16-1.
REQ-003 Port Clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port Clr, input, 1 bit, SHALL be the reset: synchronous and active-high.
REQ-005 Port Load, input, 1 bit, SHALL request loading of Din.
REQ-006 Port Din, input, WIDTH bits, SHALL be the load value.
REQ-007 Port Start, input, 1 bit, SHALL request the start of a countdown.
REQ-008 Port Pause, input, 1 bit, SHALL be a level-sensitive hold request.
REQ-009 Port AutoRld, input, 1 bit, SHALL be a level-sensitive auto-reload enable.
REQ-010 Port Q, output, WIDTH bits, SHALL be the registered count value.
REQ-011 Port Busy, output, 1 bit, SHALL be high in the RUN and HOLD states.
REQ-012 Port Done, output, 1 bit, SHALL be a registered one-cycle terminal-count pulse.
REQ-013 Port Zero, output, 1 bit, SHALL be the combinational value of (Q == 0).

Function
REQ-014 The block SHALL implement the states IDLE, RUN, HOLD and DONE.
REQ-015 The block SHALL hold a reload register (WIDTH bits) and a prescaler counter (0 to PRESCALE-1).
REQ-016 Priority per edge SHALL be Clr > Load > Start/Pause/count.
REQ-017 Load in any state SHALL set Q and the reload register to Din, clear the prescaler and Done, and go to IDLE.
REQ-018 IDLE: Start with Q != 0 SHALL go to RUN with the prescaler at 0; Start with Q == 0 SHALL be ignored.
REQ-019 RUN: the prescaler SHALL increment every cycle; when it equals PRESCALE-1 it SHALL wrap to 0 and Q SHALL decrement by 1.
REQ-020 Latency: the first decrement SHALL occur PRESCALE edges after the edge that samples Start.
REQ-021 RUN with Pause = 1 SHALL go to HOLD on that edge with no prescaler advance; HOLD SHALL freeze Q and the prescaler.
REQ-022 HOLD with Pause = 0 SHALL return to RUN and resume from the frozen prescaler value.
REQ-023 Pause SHALL be ignored in IDLE and DONE.
REQ-024 A decrement from Q = 1 with AutoRld = 0 SHALL set Q to 0, pulse Done in the same cycle Q reads 0, and go to DONE.
REQ-025 A decrement from Q = 1 with AutoRld = 1 SHALL set Q to the reload value, pulse Done, and stay in RUN.
REQ-026 In the AutoRld = 1 case, Q SHALL never read 0 and the Done period SHALL be reload × PRESCALE cycles.
REQ-027 DONE: Start with a nonzero reload value SHALL set Q to the reload value, clear the prescaler, and go to RUN; otherwise Start SHALL be ignored.
REQ-028 Start SHALL be ignored in RUN and HOLD.
REQ-029 Done SHALL be high for exactly one cycle per terminal count and SHALL never assert on Load or Clr.
REQ-030 Q SHALL never underflow, and Q arithmetic SHALL be modulo 2^WIDTH with no carry out.
REQ-031 PRESCALE = 1 SHALL decrement every RUN cycle.

Reset
REQ-032 Clr = 1 SHALL force on the next edge: state IDLE, Q = 0, reload register = 0, prescaler = 0, Done = 0, Busy = 0 (Zero therefore reads 1).
REQ-033 Clr mid-RUN, or asserted together with Load or Start, SHALL abort the operation with no Done pulse.
REQ-034 The block SHALL have no asynchronous reset path.

Verification
REQ-035 Reset: Clr high for 1 cycle with random Load/Start/Din -> Q = 0, Busy = 0, Done = 0, Zero = 1.
REQ-036 Basic count: PRESCALE = 4, Load Din = 3, Start at edge n -> Q = 2 at n+4, Q = 1 at n+8, Q = 0 at n+12 with Done high only at n+12, Busy low from n+12, state DONE.
REQ-037 Pause: Load 5, Start, Pause held 10 cycles mid-run -> Q and prescaler frozen throughout; Done at Start + 30 instead of Start + 20.
REQ-038 Auto-reload: Load 2, AutoRld = 1, Start -> Q sequence 2,1,2,1..., Done pulses every 8 cycles, Zero never asserts.
REQ-039 Preemption: Load 0x00FF during RUN -> next cycle Q = 0x00FF, IDLE, Busy = 0, no Done; Clr together with Load -> Q = 0.
REQ-040 Boundaries: Start with Q = 0 -> stays IDLE; Load 0xFFFF with PRESCALE = 1 -> Done exactly 65535 cycles after Start; Start in DONE -> restart from the reload value.

Source files
------------

// File: rtl/down_counter_timer.sv
// Prescaled down-counter timer with load, start, pause and auto-reload.
//
// Ports:
//   Clk      - single clock, all state updates on rising edge
//   Clr      - synchronous active-high reset
//   Load     - load Din into count and reload register (returns to idle)
//   Din      - load value
//   Start    - start countdown (idle) or restart from reload value (done)
//   Pause    - level-sensitive hold request while counting
//   AutoRld  - level-sensitive auto-reload at terminal count
//   Q        - registered count value
//   Busy     - high while counting or held
//   Done     - registered one-cycle terminal-count pulse
//   Zero     - combinational (Q == 0)
//
// state  | meaning
// S_IDLE | loaded or reset, waiting for Start
// S_RUN  | prescaler advancing, Q decrementing on prescaler wrap
// S_HOLD | paused, Q and prescaler frozen
// S_DONE | terminal count reached without auto-reload
module down_counter_timer #(
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 4
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  input  logic             Start,
  input  logic             Pause,
  input  logic             AutoRld,
  output logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Done,
  output logic             Zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

  localparam logic [15:0]      PRE_LAST = 16'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q, q_nxt;
  logic [WIDTH-1:0] rld, rld_nxt;
  logic [15:0]      pre, pre_nxt;
  logic             done_q, done_nxt;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state  <= S_IDLE;
      q      <= '0;
      rld    <= '0;
      pre    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      q      <= q_nxt;
      rld    <= rld_nxt;
      pre    <= pre_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    q_nxt     = q;
    rld_nxt   = rld;
    pre_nxt   = pre;
    done_nxt  = 1'b0;
    if (Load) begin
      q_nxt     = Din;
      rld_nxt   = Din;
      pre_nxt   = '0;
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (Start && (q != '0)) begin
            state_nxt = S_RUN;
            pre_nxt   = '0;
          end
        end
        S_RUN, S_HOLD: begin
          if (Pause) begin
            state_nxt = S_HOLD;
          end else begin
            // Leaving HOLD counts as a run cycle, so a pause costs exactly
            // as many cycles as Pause was sampled high.
            state_nxt = S_RUN;
            if (pre == PRE_LAST) begin
              pre_nxt = '0;
              if (q == ONE) begin
                done_nxt = 1'b1;
                if (AutoRld) begin
                  q_nxt = rld;
                end else begin
                  q_nxt     = '0;
                  state_nxt = S_DONE;
                end
              end else if (q != '0) begin
                q_nxt = q - ONE;
              end
            end else begin
              pre_nxt = pre + 16'd1;
            end
          end
        end
        S_DONE: begin
          if (Start && (rld != '0)) begin
            q_nxt     = rld;
            pre_nxt   = '0;
            state_nxt = S_RUN;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  assign Q    = q;
  assign Done = done_q;
  assign Busy = (state == S_RUN) || (state == S_HOLD);
  assign Zero = (q == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;

  logic        clk = 1'b0;
  logic        clr, load, start, pause, autorld;
  logic [15:0] din;
  logic [15:0] q;
  logic        busy, done, zero;

  logic        clr2, load2, start2, pause2, autorld2;
  logic [15:0] din2;
  logic [15:0] q2;
  logic        busy2, done2, zero2;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  down_counter_timer #(.WIDTH(16), .PRESCALE(4)) dut (
    .Clk(clk), .Clr(clr), .Load(load), .Din(din), .Start(start),
    .Pause(pause), .AutoRld(autorld), .Q(q), .Busy(busy), .Done(done), .Zero(zero)
  );

  down_counter_timer #(.WIDTH(16), .PRESCALE(1)) dut_fast (
    .Clk(clk), .Clr(clr2), .Load(load2), .Din(din2), .Start(start2),
    .Pause(pause2), .AutoRld(autorld2), .Q(q2), .Busy(busy2), .Done(done2), .Zero(zero2)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Behavioural model: a countdown that "ticks" once per PRESCALE active cycles.
  int m_q = 0, m_rld = 0, m_ticks = 0;
  bit m_active = 0, m_finished = 0, m_done = 0;
  localparam int MP = 4;

  always @(posedge clk) begin
    m_done = 0;
    if (clr) begin
      m_q = 0; m_rld = 0; m_ticks = 0;
      m_active = 0; m_finished = 0;
    end else if (load) begin
      m_q = din; m_rld = din; m_ticks = 0;
      m_active = 0; m_finished = 0;
    end else if (!m_active) begin
      if (start && !m_finished && m_q != 0) begin
        m_active = 1; m_ticks = 0;
      end else if (start && m_finished && m_rld != 0) begin
        m_active = 1; m_ticks = 0; m_q = m_rld; m_finished = 0;
      end
    end else if (!pause) begin
      m_ticks = m_ticks + 1;
      if (m_ticks == MP) begin
        m_ticks = 0;
        m_q = m_q - 1;
        if (m_q == 0) begin
          m_done = 1;
          if (autorld) m_q = m_rld;
          else begin m_active = 0; m_finished = 1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_q", q, m_q);
      chk("model_busy", busy, m_active);
      chk("model_done", done, m_done);
      chk("model_zero", zero, m_q == 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_done(input bit fast, input int bound, output int k);
    k = 0;
    for (int i = 0; i < bound; i++) begin
      cyc(1);
      k++;
      if ((fast ? done2 : done) === 1'b1) break;
    end
  endtask

  int k, nd, nz;

  initial begin
    clr = 1; load = 1; start = 1; din = 16'($urandom); pause = 0; autorld = 0;
    clr2 = 1; load2 = 0; start2 = 0; din2 = 0; pause2 = 0; autorld2 = 0;
    cyc(1);
    chk("reset_q", q, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_zero", zero, 1);
    chk_en = 1;
    clr = 0; load = 0; start = 0; clr2 = 0;

    // basic count, PRESCALE 4, load 3
    load = 1; din = 3; cyc(1); load = 0;
    start = 1; cyc(1); start = 0;
    chk("basic_n_q", q, 3);
    chk("basic_n_busy", busy, 1);
    cyc(3); chk("basic_n3_q", q, 3);
    cyc(1); chk("basic_n4_q", q, 2);
    cyc(4); chk("basic_n8_q", q, 1);
    cyc(3); chk("basic_n11_done", done, 0);
    cyc(1);
    chk("basic_n12_q", q, 0);
    chk("basic_n12_done", done, 1);
    chk("basic_n12_busy", busy, 0);
    cyc(1); chk("basic_n13_done", done, 0);

    // start in DONE restarts from reload value
    start = 1; cyc(1); start = 0;
    chk("restart_q", q, 3);
    chk("restart_busy", busy, 1);
    wait_done(0, 20, k);
    chk("restart_latency", k, 12);

    // pause for 10 cycles mid-run
    load = 1; din = 5; cyc(1); load = 0;
    start = 1; cyc(1); start = 0;
    cyc(6); chk("pause_before_q", q, 4);
    pause = 1; cyc(10); pause = 0;
    chk("pause_after_q", q, 4);
    chk("pause_after_busy", busy, 1);
    wait_done(0, 40, k);
    chk("pause_done_at", 16 + k, 30);
    pause = 1; cyc(2); pause = 0;
    chk("pause_in_done_busy", busy, 0);

    // auto-reload
    load = 1; din = 2; cyc(1); load = 0;
    autorld = 1; start = 1; cyc(1); start = 0;
    cyc(4); chk("ar_a4_q", q, 1);
    cyc(4); chk("ar_a8_q", q, 2); chk("ar_a8_done", done, 1);
    nd = 0; nz = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(1);
      if (done) nd++;
      if (zero) nz++;
    end
    chk("ar_done_count", nd, 3);
    chk("ar_zero_count", nz, 0);

    // load preempts a terminal-count edge
    cyc(7);
    load = 1; din = 16'h00FF; cyc(1); load = 0; autorld = 0;
    chk("preempt_q", q, 16'h00FF);
    chk("preempt_busy", busy, 0);
    chk("preempt_done", done, 0);

    // Clr together with Load and Start
    clr = 1; load = 1; start = 1; din = 16'h1234; cyc(1);
    clr = 0; load = 0; start = 0;
    chk("clr_load_q", q, 0);
    chk("clr_load_zero", zero, 1);

    // Start with Q == 0 ignored
    start = 1; cyc(1); start = 0;
    chk("start_zero_busy", busy, 0);
    cyc(5); chk("start_zero_q", q, 0);

    // Clr mid-run: no Done
    load = 1; din = 3; cyc(1); load = 0;
    start = 1; cyc(1); start = 0;
    cyc(5);
    clr = 1; cyc(1); clr = 0;
    chk("clr_run_q", q, 0);
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(1);
      if (done) nd++;
    end
    chk("clr_run_no_done", nd, 0);

    // PRESCALE 1, full-range count
    load2 = 1; din2 = 16'hFFFF; cyc(1); load2 = 0;
    start2 = 1; cyc(1); start2 = 0;
    chk("long_start_q", q2, 16'hFFFF);
    cyc(1); chk("long_first_dec", q2, 16'hFFFE);
    wait_done(1, 70000, k);
    chk("long_latency", k + 1, 65535);
    chk("long_end_q", q2, 0);
    chk("long_end_busy", busy2, 0);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
